// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and data width, used by both rx and tx.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2-cycle latency.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples at bit centre, 1-cycle DV / frame-error pulses.
// No backpressure: a byte is presented once and must be taken in that cycle.
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 868
`endif

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = `CLKS_PER_BIT
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  input  logic              i_RX_Serial,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic              o_RX_Frame_Err,
  output logic              o_RX_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (i_Clock),
    .rst (i_Rst_L),
    .d   (i_RX_Serial),
    .q   (rx_s)
  );

  uart_state_e       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic [DATA_W-1:0] byte_d, byte_q;
  logic              dv_d, dv_q;
  logic              ferr_d, ferr_q;
  logic              active_d, active_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START_BIT;
      end
      START_BIT: begin
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = DATA_BITS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (cnt_q == LAST_C) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          if (rx_s) begin
            byte_d = shreg_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: begin
        // Wait out a break so a stuck-low line never looks like a new start bit.
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Rst_L) begin
    if (i_Rst_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Active    = active_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the Neo PCB FPGA: recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit, no parity) from the serial input line. It pairs with the board's UART transmitter and shares its baud setting. Each accepted byte is presented for exactly one clock with a valid strobe. Stop-bit violations are flagged, glitches on the start bit are rejected, and a held-low line (break) is absorbed.

## Interface
- CLKS_PER_BIT, default `CLKS_PER_BIT` from the shared Neo PCB parameter file (868 = 100 MHz / 115200). Clocks per bit; legal range is ≥ 4.
- i_Clock  input  1  system clock, rising edge.
- i_Rst_L  input  1  reset; one clock; reset is asynchronous and active-high (resets while i_Rst_L = 1, despite the name).
- i_RX_Serial  input  1  asynchronous serial line; idles high.
- o_RX_DV  output  1  one-cycle pulse; o_RX_Byte is valid in that cycle.
- o_RX_Byte  output  8  last good byte; holds its value until the next good byte.
- o_RX_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_RX_Active  output  1  high from start-bit confirmation through the end of the frame.

## Operation
- The input passes through a 2-flop synchronizer. Its flops reset to 1. All FSM decisions use the synchronized bit `rx_s`.
- Clock counter width is $clog2(CLKS_PER_BIT)+1. HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: counter = 0, bit index = 0. When `rx_s` = 0, go to RX_START_BIT.
- RX_START_BIT: count up to HALF.
  - At count == HALF, if `rx_s` = 0: counter := 0, o_RX_Active := 1, go to RX_DATA_BITS.
  - Otherwise the start is a glitch: return to IDLE with no output activity.
- RX_DATA_BITS: count to CLKS_PER_BIT-1.
  - At terminal count, shift `rx_s` into bit[index], LSB first, and reset the counter.
  - After index 7, go to RX_STOP_BIT; otherwise increment the index.
- RX_STOP_BIT: count to CLKS_PER_BIT-1, then sample `rx_s`.
  - If 1: o_RX_Byte := shift register, o_RX_DV := 1.
  - If 0: o_RX_Frame_Err := 1, and o_RX_Byte is unchanged.
  - In both cases o_RX_Active := 0, go to CLEANUP.
- CLEANUP: o_RX_DV := 0 and o_RX_Frame_Err := 0.
  - Stay in CLEANUP while `rx_s` = 0 (break or persisting low). Go to IDLE once `rx_s` = 1.
  - A frame therefore never restarts from a stuck-low line.
- Unreachable state encodings go to IDLE.
- Reset values: o_RX_DV = 0, o_RX_Byte = 8'h00, o_RX_Frame_Err = 0, o_RX_Active = 0. State = IDLE, counter = 0, index = 0, synchronizer = 2'b11.
- Reset mid-frame aborts the frame: no DV, no error, IDLE on release.
- o_RX_DV and o_RX_Frame_Err are never high in the same cycle.

## Timing
- The synchronizer adds 2 cycles. IDLE sees a falling edge 2 cycles after it reaches i_RX_Serial.
- All sample points lie at bit centre ±1 cycle, plus the synchronizer delay.
- Back-to-back frames:
  - A stop bit of one full bit period is sufficient.
  - IDLE is re-entered within one cycle of CLEANUP, i.e. about half a bit before the nominal end of the stop bit.
  - The next start edge is therefore never missed.
- Outputs are fully registered. There is no combinational path from input to output.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP), 3 bits, also reusable by the transmitter.
  - Data width constant (8).
- CLKS_PER_BIT stays in the shared Neo PCB parameter file.
- One sub-module, `sync_2ff`: parameterizable reset value, async active-high reset. The FSM and counter stay in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT = 4 unless noted.

1. Send byte 8'hA5 with valid framing. Required: exactly one o_RX_DV pulse with o_RX_Byte = 8'hA5. o_RX_Frame_Err stays 0. o_RX_Active spans the frame.
2. Send 8'h00, 8'hFF, 8'h3C back-to-back with 1-bit stop bits. Required: three DV pulses in order, with no dropped start bit.
3. Drive a 1-cycle low glitch on an idle line. Required: no DV, no Frame_Err, o_RX_Active stays 0, FSM back in IDLE.
4. Send 8'h55 with the stop bit forced low, then hold the line low for 3 bit times, then release. Required: one Frame_Err pulse, no DV, o_RX_Byte keeps its prior value, and no new frame starts until the line goes high. A following 8'h12 is received correctly.
5. Assert reset during data bit 4 of a frame, then send 8'hC3. Required: all outputs at reset values immediately, no DV for the aborted frame, then DV with 8'hC3.
6. With CLKS_PER_BIT = 868, send 8'h7E with ±2% baud error. Required: DV with 8'h7E.
